uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per UART frame.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter CNTW, default 16, width of the frame counter.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, NREQ, per-requester level request to send one frame.
REQ-007 SHALL have port req_data, input, NREQ x WIDTH, per-requester payload.
REQ-008 SHALL have port gnt, output, NREQ, one-hot, one-cycle grant pulse.
REQ-009 SHALL have port tx_valid, output, 1, byte offered to the shared UART transmitter.
REQ-010 SHALL have port tx_data, output, WIDTH, byte offered to the transmitter.
REQ-011 SHALL have port tx_ready, input, 1, transmitter accepts a byte when tx_valid and tx_ready are both high on a clk edge.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port last_src, output, $clog2(NREQ), index of the most recent grant.
REQ-014 SHALL have port frame_cnt, output, CNTW, count of payload bytes accepted by the transmitter.

Function
REQ-015 SHALL implement states IDLE, SEND_ID and SEND_DATA.
REQ-016 In IDLE with any req bit high, SHALL select a winner round-robin, starting at index ptr and wrapping modulo NREQ.
REQ-017 In the selection cycle, SHALL pulse gnt[winner] for exactly one cycle, latch req_data[winner] and the winner index, and load last_src.
REQ-018 After the selection cycle, SHALL set ptr to (winner+1) mod NREQ, so index NREQ-1 wraps to 0.
REQ-019 After the selection cycle, SHALL go to SEND_ID when the macro is defined, else to SEND_DATA.
REQ-020 In SEND_ID and SEND_DATA, SHALL drive tx_valid high and hold tx_data stable until tx_ready; tx_valid SHALL never drop before acceptance.
REQ-021 In SEND_ID, tx_data SHALL be {1'b1, zero-padding, winner index}; on acceptance, SHALL go to SEND_DATA.
REQ-022 In SEND_DATA, tx_data SHALL be the latched payload; on acceptance, SHALL increment frame_cnt and go to IDLE.
REQ-023 frame_cnt SHALL saturate at all-ones and never wrap.
REQ-024 tx_valid and gnt SHALL be low in IDLE, except for the gnt pulse of REQ-017.
REQ-025 Outside IDLE, SHALL ignore req changes; req_data changes after the grant SHALL NOT alter tx_data.
REQ-026 Minimum spacing between grants SHALL be 2 cycles, or 3 cycles with the macro defined, when tx_ready is held high.
REQ-027 A req held high after its grant SHALL be treated as a new request, subject to round-robin.
REQ-028 With req all zero, SHALL remain in IDLE with all outputs static.

Reset
REQ-029 While reset is low, SHALL force state=IDLE, ptr=0, gnt=0, tx_valid=0, tx_data=0, busy=0, last_src=0 and frame_cnt=0, independent of clk.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; tx_valid SHALL drop asynchronously and no count SHALL be recorded.
REQ-031 After reset deasserts, the first grant SHALL favour index 0.

Configuration
REQ-032 Macro UART_ARB_ID_PREFIX_EN, when defined, SHALL enable SEND_ID, so each payload is preceded by the source-ID byte.
REQ-033 Without UART_ARB_ID_PREFIX_EN, SEND_ID logic SHALL be absent, and each frame SHALL be exactly one byte.

Verification
REQ-034 Bench SHALL cover: req=4'b0001, data0=8'hA5, tx_ready=1 -> gnt=0001 for 1 cycle; tx_data=A5 with tx_valid for 1 cycle; frame_cnt=1.
REQ-035 Bench SHALL cover: req=4'b1111 held high, tx_ready=1 -> grant order 0,1,2,3,0; last_src follows it.
REQ-036 Bench SHALL cover: grant to 2, tx_ready low for 5 cycles, req_data[2] changed meanwhile -> tx_valid held 5+ cycles, tx_data unchanged, no new gnt.
REQ-037 Bench SHALL cover: reset driven low during SEND_DATA -> tx_valid=0 immediately, frame_cnt unchanged (0); the next grant after release goes to index 0.
REQ-038 Bench SHALL cover, with UART_ARB_ID_PREFIX_EN defined: req=4'b0100, data=8'h3C -> bytes 8'h82 then 8'h3C; frame_cnt increments once.
REQ-039 Bench SHALL cover: CNTW=4, 20 frames -> frame_cnt stops at 4'hF.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// Each grant moves one frame to the transmitter over a valid/ready handshake.
// In the default build a frame is the latched payload byte alone. When the
// macro UART_ARB_ID_PREFIX_EN is defined, a source-ID byte
// {1'b1, zero padding, source index} is sent before the payload.
//
// Parameters
//   WIDTH : data bits per UART frame
//   NREQ  : number of requesters (2..8)
//   CNTW  : width of the saturating frame counter
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   reset     in   asynchronous active-low reset
//   req       in   [NREQ]         level request per requester
//   req_data  in   [NREQ][WIDTH]  payload per requester
//   gnt       out  [NREQ]         one-hot, one-cycle grant pulse
//   tx_valid  out                 byte offered to the transmitter
//   tx_data   out  [WIDTH]        byte offered to the transmitter
//   tx_ready  in                  transmitter takes the byte when valid & ready
//   busy      out                 high whenever the FSM is not idle
//   last_src  out  [clog2(NREQ)]  index of the most recent grant
//   frame_cnt out  [CNTW]         payload bytes accepted, saturating
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0][WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]               gnt,
    output logic                          tx_valid,
    output logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       last_src,
    output logic [CNTW-1:0]               frame_cnt
);

    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
`ifdef UART_ARB_ID_PREFIX_EN
        SEND_ID   = 2'd1,
`endif
        SEND_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [IDXW-1:0]     src_q, src_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    logic                sel;
    logic [IDXW-1:0]     win_idx;
    logic [IDXW-1:0]     cand_idx [NREQ];

    // ------------------------------------------------------------------
    // Round-robin search. cand_idx[gi] is the requester visited at
    // offset gi from ptr_q, wrapped modulo NREQ (NREQ need not be a
    // power of two, so an explicit subtract is used instead of masking).
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDXW:0] sum;
            assign sum = {1'b0, ptr_q} + (IDXW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDXW+1)'(NREQ))
                                ? IDXW'(sum - (IDXW+1)'(NREQ))
                                : IDXW'(sum);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest active requester
    // overwrites the result and therefore wins.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    assign sel = (state_q == IDLE) && (|req);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. req is only looked at in IDLE, so request
    // changes during a frame have no effect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
`ifdef UART_ARB_ID_PREFIX_EN
                    state_d = SEND_ID;
`else
                    state_d = SEND_DATA;
`endif
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            SEND_ID: begin
                if (tx_ready) begin
                    state_d = SEND_DATA;
                end
            end
`endif
            SEND_DATA: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. These decode state_q only, so the asynchronous reset
    // drops tx_valid and busy at once, without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        tx_valid = 1'b0;
        busy     = 1'b0;
        tx_data  = '0;
        case (state_q)
`ifdef UART_ARB_ID_PREFIX_EN
            SEND_ID: begin
                tx_valid               = 1'b1;
                busy                   = 1'b1;
                tx_data[WIDTH-1]       = 1'b1;
                tx_data[IDXW-1:0]      = src_q;
            end
`endif
            SEND_DATA: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = data_q;
            end
            default: begin
                tx_valid = 1'b0;
                busy     = 1'b0;
                tx_data  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state. The payload and source are captured only in the
    // selection cycle, so later req_data changes cannot reach tx_data.
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d  = ptr_q;
        gnt_d  = '0;
        data_d = data_q;
        src_d  = src_q;
        cnt_d  = cnt_q;
        if (sel) begin
            gnt_d[win_idx] = 1'b1;
            data_d         = req_data[win_idx];
            src_d          = win_idx;
            ptr_d          = (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
        // Count only accepted payload bytes; stick at all-ones.
        if ((state_q == SEND_DATA) && tx_ready && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            gnt_q  <= '0;
            data_q <= '0;
            src_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            data_q <= data_d;
            src_q  <= src_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign last_src  = src_q;
    assign frame_cnt = cnt_q;

endmodule
